// File: rtl/boot_ram_bus_ctrl.sv
// Boot RAM bus controller: turns 32-bit CPU valid/ready requests and a byte-wide
// loader port into per-lane CE/WRE/AD/DIN strobes for four 8-bit boot RAM lanes.
module boot_ram_bus_ctrl #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned AW        = 11
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cpu_valid,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_wstrb,
    output logic          cpu_ready,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    input  logic          ld_en,
    input  logic          ld_valid,
    input  logic [AW+1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic [3:0]    ram_ce,
    output logic          ram_oce,
    output logic          ram_reset,
    output logic [3:0]    ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);

    localparam int unsigned TAG_W = 32 - (AW + 2);
    localparam logic [TAG_W-1:0] BASE_TAG = ADDR_BASE[31:AW+2];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    logic   r_is_ld;
    logic   r_is_rd;

    logic             w_in_win;
    logic             w_cpu_wr;
    logic             w_ld_fire;
    logic [3:0]       w_ld_lane_oh;
    logic             w_unused;

    assign ram_oce   = 1'b1;
    assign ram_reset = 1'b0;

    assign w_in_win     = (cpu_addr[31:AW+2] == BASE_TAG);
    assign w_cpu_wr     = (cpu_wstrb != 4'b0000);
    assign w_ld_fire    = ld_valid & ld_ready;
    assign w_ld_lane_oh = 4'(4'b0001 << ld_addr[1:0]);
    // Byte offset within a word is irrelevant: the RAM is word-addressed per lane.
    assign w_unused     = &{1'b0, cpu_addr[1:0]};

    // Request sequencer; reset clears every strobe asynchronously so no partial write follows it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_is_ld   <= 1'b0;
            r_is_rd   <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_rdata <= 32'h0;
            cpu_err   <= 1'b0;
            ld_ready  <= 1'b0;
            ram_ce    <= 4'h0;
            ram_wre   <= 4'h0;
            ram_ad    <= '0;
            ram_din   <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ld_en) begin
                        if (w_ld_fire) begin
                            ram_ad   <= ld_addr[AW+1:2];
                            ram_din  <= {4{ld_data}};
                            ram_ce   <= w_ld_lane_oh;
                            ram_wre  <= w_ld_lane_oh;
                            ld_ready <= 1'b0;
                            r_is_ld  <= 1'b1;
                            r_is_rd  <= 1'b0;
                            r_state  <= S_ISSUE;
                        end else begin
                            ld_ready <= 1'b1;
                        end
                    end else begin
                        ld_ready <= 1'b0;
                        if (cpu_valid && !cpu_ready) begin
                            r_is_ld <= 1'b0;
                            if (!w_in_win) begin
                                // Out-of-window: answer immediately without touching the RAM.
                                cpu_err   <= 1'b1;
                                cpu_rdata <= 32'h0;
                                cpu_ready <= 1'b1;
                                r_is_rd   <= 1'b0;
                                r_state   <= S_RESP;
                            end else begin
                                ram_ad  <= cpu_addr[AW+1:2];
                                r_state <= S_ISSUE;
                                if (w_cpu_wr) begin
                                    ram_din <= cpu_wdata;
                                    ram_ce  <= cpu_wstrb;
                                    ram_wre <= cpu_wstrb;
                                    r_is_rd <= 1'b0;
                                end else begin
                                    ram_ce  <= 4'hF;
                                    ram_wre <= 4'h0;
                                    r_is_rd <= 1'b1;
                                end
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    ram_ce  <= 4'h0;
                    ram_wre <= 4'h0;
                    if (r_is_ld) begin
                        ld_ready <= ld_en;
                        r_state  <= S_IDLE;
                    end else if (r_is_rd) begin
                        r_state <= S_WAIT;
                    end else begin
                        cpu_ready <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_WAIT: begin
                    cpu_rdata <= ram_dout;
                    cpu_ready <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    ld_ready  <= ld_en;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_ram_bus_ctrl.sv
// Directed bench for boot_ram_bus_ctrl with a behavioural four-lane boot RAM model.
module tb_boot_ram_bus_ctrl;

    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cpu_valid = 1'b0;
    logic [31:0]   cpu_addr = 32'h0;
    logic [31:0]   cpu_wdata = 32'h0;
    logic [3:0]    cpu_wstrb = 4'h0;
    logic          cpu_ready;
    logic [31:0]   cpu_rdata;
    logic          cpu_err;
    logic          ld_en = 1'b0;
    logic          ld_valid = 1'b0;
    logic [AW+1:0] ld_addr = '0;
    logic [7:0]    ld_data = 8'h0;
    logic          ld_ready;
    logic [3:0]    ram_ce;
    logic          ram_oce;
    logic          ram_reset;
    logic [3:0]    ram_wre;
    logic [AW-1:0] ram_ad;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    logic       mem_clear = 1'b1;
    logic [7:0] mem [4][2**AW];

    boot_ram_bus_ctrl #(.ADDR_BASE(32'h0000_0000), .AW(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .ld_en     (ld_en),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_reset (ram_reset),
        .ram_wre   (ram_wre),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port lane model: write on CE&WRE, registered read data on CE&!WRE.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_clear) begin
                for (int a = 0; a < 2**AW; a++) mem[k][a] <= 8'h00;
            end else if (ram_ce[k]) begin
                if (ram_wre[k]) mem[k][ram_ad] <= ram_din[8*k +: 8];
                else            ram_dout[8*k +: 8] <= mem[k][ram_ad];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one CPU request from IDLE; reports latency and the strobes seen after the accept edge.
    task automatic cpu_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output logic [3:0] ce1, output logic [3:0] wre1, output logic [AW-1:0] ad1);
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wstrb = wstrb;
        cpu_valid = 1'b1;
        lat = 0;
        ce1 = 4'h0; wre1 = 4'h0; ad1 = '0;
        forever begin
            tick();
            lat++;
            if (lat == 1) begin
                ce1 = ram_ce; wre1 = ram_wre; ad1 = ram_ad;
            end
            if (cpu_ready) break;
            if (lat >= 20) begin
                check("cpu_timeout", 32'(lat), 32'(0));
                break;
            end
        end
        rdata = cpu_rdata;
        err   = cpu_err;
        cpu_valid = 1'b0;
        tick();
        check("ready_one_cycle", 32'(cpu_ready), 32'(0));
    endtask

    logic [31:0]   rd;
    logic          er;
    int            lat;
    logic [3:0]    ce1;
    logic [3:0]    wre1;
    logic [AW-1:0] ad1;

    initial begin
        // Reset state
        tick();
        tick();
        mem_clear = 1'b0;
        check("rst_cpu_ready", 32'(cpu_ready), 32'(0));
        check("rst_ld_ready",  32'(ld_ready),  32'(0));
        check("rst_ram_ce",    32'(ram_ce),    32'(0));
        check("rst_ram_wre",   32'(ram_wre),   32'(0));
        check("rst_ram_ad",    32'(ram_ad),    32'(0));
        check("rst_ram_din",   ram_din,        32'h0);
        check("rst_cpu_rdata", cpu_rdata,      32'h0);
        check("ram_oce_tie",   32'(ram_oce),   32'(1));
        check("ram_reset_tie", 32'(ram_reset), 32'(0));
        resetn = 1'b1;
        tick();

        // Word write then read
        cpu_txn(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat, ce1, wre1, ad1);
        check("wr_lat", 32'(lat), 32'(2));
        check("wr_wre", 32'(wre1), 32'(4'hF));
        check("wr_ad",  32'(ad1),  32'(4));
        check("wr_err", 32'(er),   32'(0));
        cpu_txn(32'h0000_0010, 32'h0, 4'h0, rd, er, lat, ce1, wre1, ad1);
        check("rd_lat",   32'(lat),  32'(3));
        check("rd_ce",    32'(ce1),  32'(4'hF));
        check("rd_wre",   32'(wre1), 32'(0));
        check("rd_data",  rd,        32'hDEAD_BEEF);

        // Byte strobe
        cpu_txn(32'h0000_0010, 32'h1122_3344, 4'b0100, rd, er, lat, ce1, wre1, ad1);
        check("bs_wre", 32'(wre1), 32'(4'b0100));
        cpu_txn(32'h0000_0012, 32'h0, 4'h0, rd, er, lat, ce1, wre1, ad1);
        check("bs_data", rd, 32'hDE22_BEEF);

        // Out of window
        cpu_txn(32'h0000_2000, 32'h0, 4'h0, rd, er, lat, ce1, wre1, ad1);
        check("oow_err",   32'(er),  32'(1));
        check("oow_rdata", rd,       32'h0);
        check("oow_ce",    32'(ce1), 32'(0));
        check("oow_lat",   32'(lat), 32'(1));
        check("oow_err_clr", 32'(cpu_err), 32'(0));

        // Loader stream, 1 byte per 2 cycles
        ld_en = 1'b1;
        tick();
        check("ld_ready_up", 32'(ld_ready), 32'(1));
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_addr  = (AW+2)'(i);
            ld_data  = 8'(8'hA0 + i);
            for (int w = 0; w < 10 && !ld_ready; w++) tick();
            check("ld_ready_wait", 32'(ld_ready), 32'(1));
            tick();
            check("ld_wre",      32'(ram_wre),  32'(4'(4'b0001 << i)));
            check("ld_ad",       32'(ram_ad),   32'(0));
            check("ld_din",      ram_din,       {4{8'(8'hA0 + i)}});
            check("ld_ready_lo", 32'(ld_ready), 32'(0));
        end
        ld_valid = 1'b0;
        tick();
        check("ld_ready_back", 32'(ld_ready), 32'(1));
        ld_en = 1'b0;
        tick();
        cpu_txn(32'h0000_0000, 32'h0, 4'h0, rd, er, lat, ce1, wre1, ad1);
        check("ld_readback", rd, 32'hA3A2_A1A0);

        // Arbitration: loader wins while ld_en is high
        ld_en = 1'b1;
        tick();
        cpu_addr  = 32'h0000_0010;
        cpu_wstrb = 4'h0;
        cpu_valid = 1'b1;
        ld_valid  = 1'b1;
        ld_addr   = (AW+2)'(5);
        ld_data   = 8'h5A;
        tick();
        check("arb_ld_wre",    32'(ram_wre),   32'(4'b0010));
        check("arb_ld_ad",     32'(ram_ad),    32'(1));
        check("arb_cpu_stall", 32'(cpu_ready), 32'(0));
        ld_valid = 1'b0;
        tick();
        tick();
        check("arb_cpu_stall2", 32'(cpu_ready), 32'(0));
        check("arb_no_ce",      32'(ram_ce),    32'(0));
        ld_en = 1'b0;
        lat = 0;
        forever begin
            tick();
            lat++;
            if (cpu_ready || lat >= 20) break;
        end
        check("arb_rd_lat",  32'(lat),  32'(3));
        check("arb_rd_data", cpu_rdata, 32'hDE22_BEEF);
        cpu_valid = 1'b0;
        tick();
        cpu_txn(32'h0000_0004, 32'h0, 4'h0, rd, er, lat, ce1, wre1, ad1);
        check("arb_ld_byte", rd, 32'h0000_5A00);

        // Reset asserted mid-ISSUE must abort the write
        cpu_txn(32'h0000_0020, 32'h1234_5678, 4'hF, rd, er, lat, ce1, wre1, ad1);
        cpu_addr  = 32'h0000_0020;
        cpu_wdata = 32'hFFFF_FFFF;
        cpu_wstrb = 4'hF;
        cpu_valid = 1'b1;
        tick();
        check("mid_issue_wre", 32'(ram_wre), 32'(4'hF));
        resetn = 1'b0;
        #1;
        check("arst_ce",    32'(ram_ce),    32'(0));
        check("arst_wre",   32'(ram_wre),   32'(0));
        check("arst_ready", 32'(cpu_ready), 32'(0));
        cpu_valid = 1'b0;
        cpu_wstrb = 4'h0;
        #3;
        tick();
        resetn = 1'b1;
        tick();
        cpu_txn(32'h0000_0020, 32'h0, 4'h0, rd, er, lat, ce1, wre1, ad1);
        check("arst_idle_lat", 32'(lat), 32'(3));
        check("arst_no_write", rd,       32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
